fabric_config_ctrl: RTL and testbench

Bitstream-driven configuration controller for the FPGA fabric. It accepts a stream of 32-bit bitstream words, assembles one configuration frame at a time across all rows, and pulses one per-column/per-frame strobe so the fabric latches that frame. It sits between the bitstream source and the fabric's `FrameData`/`FrameStrobe` inputs. It also reports busy and configured status to the fabric wrapper and the warmboot logic.

---
 rtl/fabric_config_ctrl.sv | 175 +++++++++++++++++
 tb/tb_fabric_config_ctrl.sv | 211 +++++++++++++++++++++
 2 files changed

// File: rtl/fabric_config_ctrl.sv
// Bitstream-driven configuration controller: assembles one frame per column/frame
// address from 32-bit words and strobes it into the fabric. Optional checksum: FABRIC_CONFIG_CHECKSUM_EN.
module fabric_config_ctrl #(
  parameter int unsigned FrameBitsPerRow = 32,
  parameter int unsigned MaxFramesPerCol = 20,
  parameter int unsigned NumColumns      = 9,
  parameter int unsigned NumRows         = 14
) (
  input  logic                                  clk_i,
  input  logic                                  rst_ni,
  input  logic [31:0]                           bitstream_data_i,
  input  logic                                  bitstream_valid_i,
  output logic                                  busy_o,
  output logic                                  configured_o,
  output logic [FrameBitsPerRow*NumRows-1:0]    FrameData_o,
  output logic [MaxFramesPerCol*NumColumns-1:0] FrameStrobe_o
);

  localparam int unsigned StrobeW = MaxFramesPerCol * NumColumns;
  localparam int unsigned DataW   = FrameBitsPerRow * NumRows;
  localparam int unsigned RowW    = (NumRows > 1) ? $clog2(NumRows) : 1;
  localparam logic [31:0] SyncWord = 32'hFAB0_FAB1;
  localparam logic [7:0]  NumColumnsB = 8'(NumColumns);
  localparam logic [7:0]  MaxFramesB  = 8'(MaxFramesPerCol);

`ifdef FABRIC_CONFIG_CHECKSUM_EN
  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_HEADER = 3'd1,
    S_DATA   = 3'd2,
    S_STROBE = 3'd3,
    S_CHECK  = 3'd4
  } state_e;
`else
  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_HEADER = 3'd1,
    S_DATA   = 3'd2,
    S_STROBE = 3'd3
  } state_e;
`endif

  state_e               state_q, state_d;
  logic [7:0]           col_q, col_d;
  logic [7:0]           frame_q, frame_d;
  logic [RowW-1:0]      row_q, row_d;
  logic                 busy_q, busy_d;
  logic                 cfg_q, cfg_d;
  logic [DataW-1:0]     data_q, data_d;
  logic [StrobeW-1:0]   strobe_q, strobe_d;
  logic [15:0]          strobe_idx;
  logic                 addr_in_range;
`ifdef FABRIC_CONFIG_CHECKSUM_EN
  logic [31:0]          xor_q, xor_d;
`endif

  assign strobe_idx    = 16'(col_q) * 16'(MaxFramesPerCol) + 16'(frame_q);
  assign addr_in_range = (col_q < NumColumnsB) && (frame_q < MaxFramesB);

  always_comb begin
    state_d  = state_q;
    col_d    = col_q;
    frame_d  = frame_q;
    row_d    = row_q;
    busy_d   = busy_q;
    cfg_d    = cfg_q;
    data_d   = data_q;
    strobe_d = '0;
`ifdef FABRIC_CONFIG_CHECKSUM_EN
    xor_d    = xor_q;
`endif
    case (state_q)
      S_IDLE: begin
        if (bitstream_valid_i && (bitstream_data_i == SyncWord)) begin
          busy_d  = 1'b1;
          cfg_d   = 1'b0;
          state_d = S_HEADER;
`ifdef FABRIC_CONFIG_CHECKSUM_EN
          xor_d   = '0;
`endif
        end
      end
      // STROBE shares header decoding: a word arriving during the strobe cycle is the next header.
      S_HEADER, S_STROBE: begin
        state_d = S_HEADER;
        if (bitstream_valid_i) begin
          if (bitstream_data_i == SyncWord) begin
            busy_d  = 1'b1;
            cfg_d   = 1'b0;
`ifdef FABRIC_CONFIG_CHECKSUM_EN
            xor_d   = '0;
`endif
          end else if (bitstream_data_i[31]) begin
`ifdef FABRIC_CONFIG_CHECKSUM_EN
            state_d = S_CHECK;
`else
            state_d = S_IDLE;
            busy_d  = 1'b0;
            cfg_d   = 1'b1;
`endif
          end else begin
            col_d   = bitstream_data_i[15:8];
            frame_d = bitstream_data_i[7:0];
            row_d   = '0;
            state_d = S_DATA;
          end
        end
      end
      S_DATA: begin
        if (bitstream_valid_i) begin
          for (int unsigned r = 0; r < NumRows; r++) begin
            if (row_q == RowW'(r)) begin
              data_d[r*FrameBitsPerRow +: FrameBitsPerRow] = bitstream_data_i;
            end
          end
`ifdef FABRIC_CONFIG_CHECKSUM_EN
          xor_d = xor_q ^ bitstream_data_i;
`endif
          if (row_q == RowW'(NumRows - 1)) begin
            state_d = S_STROBE;
            for (int unsigned i = 0; i < StrobeW; i++) begin
              strobe_d[i] = addr_in_range && (strobe_idx == 16'(i));
            end
          end else begin
            row_d = row_q + 1'b1;
          end
        end
      end
`ifdef FABRIC_CONFIG_CHECKSUM_EN
      S_CHECK: begin
        if (bitstream_valid_i) begin
          state_d = S_IDLE;
          busy_d  = 1'b0;
          cfg_d   = (bitstream_data_i == xor_q);
        end
      end
`endif
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      state_q  <= S_IDLE;
      col_q    <= '0;
      frame_q  <= '0;
      row_q    <= '0;
      busy_q   <= 1'b0;
      cfg_q    <= 1'b0;
      data_q   <= '0;
      strobe_q <= '0;
`ifdef FABRIC_CONFIG_CHECKSUM_EN
      xor_q    <= '0;
`endif
    end else begin
      state_q  <= state_d;
      col_q    <= col_d;
      frame_q  <= frame_d;
      row_q    <= row_d;
      busy_q   <= busy_d;
      cfg_q    <= cfg_d;
      data_q   <= data_d;
      strobe_q <= strobe_d;
`ifdef FABRIC_CONFIG_CHECKSUM_EN
      xor_q    <= xor_d;
`endif
    end
  end

  assign busy_o        = busy_q;
  assign configured_o  = cfg_q;
  assign FrameData_o   = data_q;
  assign FrameStrobe_o = strobe_q;

endmodule

// File: tb/tb_fabric_config_ctrl.sv
// Directed bench for fabric_config_ctrl: vector table plus hand sequences for
// out-of-range frames, valid gaps, mid-frame reset and (if enabled) checksum.
module tb_fabric_config_ctrl;
  localparam int NR = 14;
  localparam int SW = 180;

  logic              clk = 1'b0;
  logic              rst_n = 1'b0;
  logic              valid = 1'b0;
  logic [31:0]       data = '0;
  logic              busy, cfg;
  logic [NR*32-1:0]  fd;
  logic [SW-1:0]     fs;

  fabric_config_ctrl #(
    .FrameBitsPerRow(32),
    .MaxFramesPerCol(20),
    .NumColumns(9),
    .NumRows(14)
  ) dut (
    .clk_i(clk),
    .rst_ni(rst_n),
    .bitstream_data_i(data),
    .bitstream_valid_i(valid),
    .busy_o(busy),
    .configured_o(cfg),
    .FrameData_o(fd),
    .FrameStrobe_o(fs)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        v;
    logic [31:0] d;
    logic        busy;
    logic        cfg;
    int          sidx;
  } vec_t;

  vec_t        vecs[24];
  int          nv = 0;
  int          checks = 0;
  int          errors = 0;
  int          strobe_cnt = 0;
  int          strobe_last = -1;
  logic [31:0] tb_xor = '0;

  function automatic int sidx(input logic [SW-1:0] s);
    int n = 0;
    int idx = -1;
    for (int i = 0; i < SW; i++) begin
      if (s[i]) begin
        n++;
        idx = i;
      end
    end
    if (n > 1) return -2;
    return idx;
  endfunction

  task automatic chk(input string name, input longint act, input longint exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h)", name, act, act, exp, exp);
    end
  endtask

  task automatic step(input logic v, input logic [31:0] d);
    valid = v;
    data  = d;
    @(posedge clk);
    #1;
    if (fs != '0) begin
      strobe_cnt++;
      strobe_last = sidx(fs);
    end
  endtask

  task automatic add(input logic v, input logic [31:0] d, input logic b, input logic c, input int s);
    vecs[nv] = '{v: v, d: d, busy: b, cfg: c, sidx: s};
    nv++;
  endtask

  task automatic do_sync();
    step(1'b1, 32'hFAB0_FAB1);
    tb_xor = '0;
  endtask

  task automatic send_frame(input logic [31:0] hdr, input logic [31:0] base, input bit gaps);
    step(1'b1, hdr);
    for (int k = 0; k < NR; k++) begin
      if (gaps) repeat ($urandom_range(0, 3)) step(1'b0, $urandom);
      step(1'b1, base + 32'(k));
      tb_xor = tb_xor ^ (base + 32'(k));
    end
  endtask

  task automatic check_data(input string name, input logic [31:0] base);
    for (int k = 0; k < NR; k++)
      chk($sformatf("%s_row%0d", name, k), fd[k*32 +: 32], base + 32'(k));
  endtask

  task automatic end_session(input string name, input bit ok);
    step(1'b1, 32'h8000_0000);
`ifdef FABRIC_CONFIG_CHECKSUM_EN
    chk({name, "_check_busy"}, busy, 1);
    chk({name, "_check_cfg"}, cfg, 0);
    step(1'b1, ok ? tb_xor : (tb_xor ^ 32'h0000_0001));
`endif
    chk({name, "_end_busy"}, busy, 0);
    chk({name, "_end_cfg"}, cfg, ok);
  endtask

  initial begin
    repeat (3) step(1'b0, 32'h0);
    chk("rst_busy", busy, 0);
    chk("rst_cfg", cfg, 0);
    chk("rst_data_zero", (fd == '0), 1);
    chk("rst_strobe_zero", (fs == '0), 1);
    rst_n = 1'b1;

    // Table: idle rejection, sync, one frame to col 3 frame 5, end.
    add(1'b1, 32'h1234_5678, 1'b0, 1'b0, -1);
    add(1'b1, 32'hFFFF_FFFF, 1'b0, 1'b0, -1);
    add(1'b0, 32'hFAB0_FAB1, 1'b0, 1'b0, -1);
    add(1'b1, 32'hFAB0_FAB1, 1'b1, 1'b0, -1);
    add(1'b1, 32'h0000_0305, 1'b1, 1'b0, -1);
    for (int k = 0; k < NR; k++)
      add(1'b1, 32'h1000_0000 + 32'(k), 1'b1, 1'b0, (k == NR - 1) ? 65 : -1);
    add(1'b0, 32'h0, 1'b1, 1'b0, -1);
`ifdef FABRIC_CONFIG_CHECKSUM_EN
    add(1'b1, 32'h8000_0000, 1'b1, 1'b0, -1);
    add(1'b1, 32'h0000_0001, 1'b0, 1'b1, -1);
`else
    add(1'b1, 32'h8000_0000, 1'b0, 1'b1, -1);
`endif
    strobe_cnt = 0;
    for (int i = 0; i < nv; i++) begin
      step(vecs[i].v, vecs[i].d);
      chk($sformatf("tab%0d_busy", i), busy, vecs[i].busy);
      chk($sformatf("tab%0d_cfg", i), cfg, vecs[i].cfg);
      chk($sformatf("tab%0d_strobe", i), sidx(fs), vecs[i].sidx);
    end
    chk("tab_strobe_cycles", strobe_cnt, 1);
    check_data("tab", 32'h1000_0000);

    // Out-of-range frames dropped; headers arrive in the strobe cycle.
    strobe_cnt = 0;
    do_sync();
    chk("oor_sync_busy", busy, 1);
    chk("oor_sync_cfg_cleared", cfg, 0);
    send_frame(32'h0000_0900, 32'h2000_0000, 1'b0);
    send_frame(32'h0000_0014, 32'h2100_0000, 1'b0);
    chk("oor_no_strobe", strobe_cnt, 0);
    send_frame(32'h0000_0813, 32'h2200_0000, 1'b0);
    step(1'b0, 32'h0);
    chk("oor_last_strobe_cycles", strobe_cnt, 1);
    chk("oor_last_strobe_bit", strobe_last, 179);
    check_data("oor", 32'h2200_0000);
    end_session("oor", 1'b1);

    // Valid gaps between every word.
    strobe_cnt = 0;
    do_sync();
    send_frame(32'h7FFF_0102, 32'h4000_0000, 1'b1);
    repeat (3) step(1'b0, $urandom);
    chk("gap_strobe_cycles", strobe_cnt, 1);
    chk("gap_strobe_bit", strobe_last, 22);
    check_data("gap", 32'h4000_0000);
    end_session("gap", 1'b1);

    // Reset mid-DATA after 7 words.
    strobe_cnt = 0;
    do_sync();
    step(1'b1, 32'h0000_0305);
    for (int k = 0; k < 7; k++) step(1'b1, 32'h5000_0000 + 32'(k));
    rst_n = 1'b0;
    step(1'b1, 32'h5000_0007);
    chk("mrst_busy", busy, 0);
    chk("mrst_cfg", cfg, 0);
    chk("mrst_data_zero", (fd == '0), 1);
    rst_n = 1'b1;
    for (int k = 8; k < NR; k++) step(1'b1, 32'h5000_0000 + 32'(k));
    repeat (2) step(1'b0, 32'h0);
    chk("mrst_no_strobe", strobe_cnt, 0);
    chk("mrst_idle_busy", busy, 0);

    do_sync();
    send_frame(32'h0000_0000, 32'h3000_0000, 1'b0);
    step(1'b0, 32'h0);
    chk("resync_strobe_cycles", strobe_cnt, 1);
    chk("resync_strobe_bit", strobe_last, 0);
    check_data("resync", 32'h3000_0000);
    end_session("resync", 1'b1);
    do_sync();
    chk("resync2_cfg_cleared", cfg, 0);
    chk("resync2_busy", busy, 1);
    end_session("empty", 1'b1);

`ifdef FABRIC_CONFIG_CHECKSUM_EN
    do_sync();
    send_frame(32'h0000_0101, 32'h5500_0000, 1'b0);
    end_session("badsum", 1'b0);
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
